mux4_rr_arbiter: RTL and testbench

- Round-robin arbiter sharing one 4-to-1 multiplexer path among four requesters.
- Drives the mux 2-bit select, a one-hot grant vector and a busy flag.
- Lets each requester own the shared output line until it drops its request, or until a hold limit forces handoff to a waiting requester.
- Sits directly in front of the gate-level 4:1 mux; sel connects to the mux S input.

---
 rtl/mux4_rr_arbiter_if.sv | 13 +
 rtl/mux4_rr_arbiter.sv | 98 +++++++++
 tb/tb_mux4_rr_arbiter.sv | 110 +++++++++++
 3 files changed

// File: rtl/mux4_rr_arbiter_if.sv
// mux4_rr_arbiter_if: request/grant bundle between four requesters and the shared-mux arbiter.
//   req  : per-requester request, driven by the requester side (master)
//   gnt  : one-hot registered grant, driven by the arbiter (slave)
//   sel  : binary owner index feeding the 4:1 mux S input
//   busy : high while any grant is held
interface mux4_rr_arbiter_if;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    modport master (output req, input gnt, sel, busy);
    modport slave  (input req, output gnt, sel, busy);
endinterface

// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin owner selection for one shared 4:1 mux path, with a hold limit.
//   clk      : system clock, rising edge
//   rst      : synchronous active-high reset
//   bus.req  : request per requester (input)
//   bus.gnt  : one-hot grant, registered, zero when idle (output)
//   bus.sel  : owner index to mux S, registered, holds last value when idle (output)
//   bus.busy : OR of gnt (output)
module mux4_rr_arbiter #(
    parameter int MAX_HOLD = 8
) (
    input  logic               clk,
    input  logic               rst,
    mux4_rr_arbiter_if.slave   bus
);
    localparam int HW = $clog2(MAX_HOLD);
    localparam logic [HW-1:0] HMAX = HW'(MAX_HOLD - 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t        state_q, state_d;
    logic [3:0]    gnt_q, gnt_d;
    logic [1:0]    sel_q, sel_d;
    logic [1:0]    ptr_q, ptr_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic [3:0]    others;
    logic [1:0]    nxt;
    logic [1:0]    first;

    // First asserted bit of r searching s, s+1, s+2, s+3 (mod 4); scanning
    // downward lets the smallest offset overwrite the result last.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] s);
        logic [1:0] idx;
        rr_pick = s;
        for (int j = 3; j >= 0; j--) begin
            idx = s + 2'(j);
            if (r[idx]) rr_pick = idx;
        end
    endfunction

    // Waiting requesters other than the current owner; on release req[owner]
    // is low so this equals req and serves both handoff cases.
    assign others = bus.req & ~gnt_q;
    assign nxt    = rr_pick(others, sel_q + 2'd1);
    assign first  = rr_pick(bus.req, ptr_q);

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        hcnt_d  = hcnt_q;
        if (state_q == IDLE) begin
            if (bus.req != 4'b0000) begin
                gnt_d   = 4'b0001 << first;
                sel_d   = first;
                hcnt_d  = '0;
                state_d = GRANT;
            end
        end else if (!bus.req[sel_q]) begin
            ptr_d  = sel_q + 2'd1;
            hcnt_d = '0;
            if (others != 4'b0000) begin
                gnt_d = 4'b0001 << nxt;
                sel_d = nxt;
            end else begin
                gnt_d   = 4'b0000;
                state_d = IDLE;
            end
        end else if (hcnt_q == HMAX && others != 4'b0000) begin
            gnt_d  = 4'b0001 << nxt;
            sel_d  = nxt;
            ptr_d  = sel_q + 2'd1;
            hcnt_d = '0;
        end else begin
            hcnt_d = (hcnt_q == HMAX) ? hcnt_q : hcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= 4'b0000;
            sel_q   <= 2'b00;
            ptr_q   <= 2'b00;
            hcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            hcnt_q  <= hcnt_d;
        end
    end

    assign bus.gnt  = gnt_q;
    assign bus.sel  = sel_q;
    assign bus.busy = |gnt_q;
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb_mux4_rr_arbiter: directed vector table plus hand sequences for hold, round-robin, preempt and reset.
module tb_mux4_rr_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;

    mux4_rr_arbiter_if ifc();
    mux4_rr_arbiter #(.MAX_HOLD(8)) dut (.clk(clk), .rst(rst), .bus(ifc.slave));

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       busy;
    } vec_t;

    vec_t tbl[14];

    task automatic step(input logic r, input logic [3:0] rq);
        @(negedge clk);
        rst     = r;
        ifc.req = rq;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [3:0] eg, input logic [1:0] es, input logic eb);
        n_chk++;
        if (ifc.gnt !== eg || ifc.sel !== es || ifc.busy !== eb) begin
            n_fail++;
            $display("FAIL %s: got gnt=%b sel=%0d busy=%b, expected gnt=%b sel=%0d busy=%b",
                     name, ifc.gnt, ifc.sel, ifc.busy, eg, es, eb);
        end
    endtask

    initial begin
        ifc.req = 4'b1111;
        tbl = '{
            '{1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0},
            '{1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0},
            '{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0},
            '{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0},
            '{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0},
            '{1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1},
            '{1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1},
            '{1'b0, 4'b0000, 4'b0000, 2'd2, 1'b0},
            '{1'b0, 4'b0010, 4'b0010, 2'd1, 1'b1},
            '{1'b0, 4'b0000, 4'b0000, 2'd1, 1'b0},
            '{1'b0, 4'b1001, 4'b1000, 2'd3, 1'b1},
            '{1'b0, 4'b1001, 4'b1000, 2'd3, 1'b1},
            '{1'b0, 4'b0001, 4'b0001, 2'd0, 1'b1},
            '{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0}
        };
        for (int i = 0; i < 14; i++) begin
            step(tbl[i].rst, tbl[i].req);
            check($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].sel, tbl[i].busy);
        end

        step(1'b0, 4'b0100);
        check("solo_grant", 4'b0100, 2'd2, 1'b1);
        for (int c = 0; c < 20; c++) begin
            step(1'b0, 4'b0100);
            check($sformatf("solo_hold%0d", c), 4'b0100, 2'd2, 1'b1);
        end
        step(1'b0, 4'b0000);
        check("solo_release", 4'b0000, 2'd2, 1'b0);

        step(1'b1, 4'b0000);
        check("rr_reset", 4'b0000, 2'd0, 1'b0);
        step(1'b0, 4'b1111);
        check("rr_first", 4'b0001, 2'd0, 1'b1);
        for (int o = 0; o < 4; o++) begin
            logic [1:0] n;
            n = 2'(o + 1);
            step(1'b0, 4'b1111 & ~(4'b0001 << o));
            check($sformatf("rr_handoff%0d", o), 4'b0001 << n, n, 1'b1);
        end
        step(1'b0, 4'b0000);
        check("rr_idle", 4'b0000, 2'd0, 1'b0);

        step(1'b1, 4'b0000);
        step(1'b0, 4'b0010);
        check("pre_grant1", 4'b0010, 2'd1, 1'b1);
        for (int c = 1; c <= 8; c++) begin
            step(1'b0, (c >= 2) ? 4'b1010 : 4'b0010);
            if (c < 8) check($sformatf("pre_hold%0d", c), 4'b0010, 2'd1, 1'b1);
            else       check("pre_move", 4'b1000, 2'd3, 1'b1);
        end

        step(1'b0, 4'b0000);
        check("mid_idle", 4'b0000, 2'd3, 1'b0);
        step(1'b0, 4'b0010);
        check("mid_g1", 4'b0010, 2'd1, 1'b1);
        step(1'b0, 4'b0000);
        check("mid_rel1", 4'b0000, 2'd1, 1'b0);
        step(1'b0, 4'b0100);
        check("mid_g2", 4'b0100, 2'd2, 1'b1);
        step(1'b1, 4'b0100);
        check("mid_reset", 4'b0000, 2'd0, 1'b0);
        step(1'b0, 4'b1010);
        check("mid_ptr0", 4'b0010, 2'd1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
